ntt_seq: RTL and testbench
==========================

Name: ntt_seq

Overview:
- Stage sequencer and address generator that drives one butterfly unit (BFU) from the coefficient and twiddle RAMs, and schedules write-back of the BFU results.
- It issues operand addresses, the twiddle address and the BFU op code. It also delays the read addresses so they arrive as write addresses exactly when the BFU results appear.
- Supported transforms: forward NTT (Cooley-Tukey), inverse NTT (Gentleman-Sande) and pointwise multiply.
- It sits between the top-level controller (start/done) and the RAM/BFU datapath.

Parameters:
- LOGN, 8, log2 of the polynomial length N (N = 1<<LOGN).
- RD_LAT, 1, read latency of the coefficient and twiddle RAMs, in cycles.
- BFU_LAT, 8, BFU input-to-output latency, in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request, sampled only in IDLE
- mode  in  2  0 = NTT, 1 = INTT, 2 = pointwise, 3 = reserved
- busy  out  1  high from the first RUN cycle through the DONE cycle
- done  out  1  one-cycle pulse when the last write has been issued
- rd_en  out  1  RAM read strobe
- rd_addr1  out  LOGN  address of BFU in1 operand
- rd_addr2  out  LOGN  address of BFU in2 operand
- rd_bsel  out  1  1 = in2 is read from the second-operand bank (pointwise mode)
- tw_addr  out  LOGN  twiddle ROM address
- tw_inv  out  1  selects the inverse twiddle table (INTT)
- op  out  2  BFU op code, aligned with RAM read data (RD_LAT after rd_en)
- op_vld  out  1  BFU input valid, aligned with op
- wr_en1  out  1  write strobe for BFU out1
- wr_en2  out  1  write strobe for BFU out2
- wr_addr1  out  LOGN  write address for out1
- wr_addr2  out  LOGN  write address for out2

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-operation aborts: pending write strobes are dropped and there is no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1 and mode!=3. start with mode=3, or start while not in IDLE, is ignored.
  - RUN issues one operation per cycle, index j = 0..M-1, with M = N/2 (NTT/INTT) or N (pointwise). After j = M-1 the FSM enters DRAIN.
  - DRAIN lasts RD_LAT+BFU_LAT cycles. Then it either goes to RUN with stage+1 and j=0, or to DONE if the last stage just finished.
  - DONE lasts one cycle (done=1), then IDLE.
- Stage count: LOGN for NTT/INTT; 1 for pointwise.
- rd_en=1 exactly in RUN cycles.
- NTT, stage s (len = N>>(s+1)):
  - g = j>>(LOGN-1-s), k = j & (len-1)
  - rd_addr1 = 2*g*len + k, rd_addr2 = rd_addr1 + len
  - tw_addr = (1<<s) + g, tw_inv = 0, op = 2'b00
- INTT, stage s (len = 1<<s):
  - g = j>>s, k = j & (len-1)
  - rd_addr1 = 2*g*len + k, rd_addr2 = rd_addr1 + len
  - tw_addr = (N>>(s+1)) + g, tw_inv = 1, op = 2'b01
- Pointwise: rd_addr1 = rd_addr2 = j, rd_bsel = 1, tw_addr = 0, op = 2'b10.
- All address arithmetic is LOGN bits wide; no carry out occurs by construction.
- op and op_vld are delayed RD_LAT cycles from the issue cycle. In non-valid cycles op holds 2'b00.
- Write-back:
  - wr_en1, wr_addr1 and wr_addr2 are rd_en/rd_addr delayed RD_LAT+BFU_LAT cycles.
  - wr_en2 follows the same delay but is forced to 0 for pointwise-mode issues.
  - The delay line carries a mode tag per entry.
- Stage-boundary hazard: the last write of stage s lands on the cycle before the first read of stage s+1; DRAIN guarantees this. No read/write overlap occurs within a stage, because the addresses are disjoint.
- Cycle budget (start sampled at cycle 0):
  - The first RUN cycle is 1.
  - done is asserted at cycle 1 + stages*(M + RD_LAT + BFU_LAT).
  - The last wr_en is in the cycle before done.

Test Plan:
- LOGN=3, mode=0, start at cycle 0:
  - stage0 pairs (0,4)(1,5)(2,6)(3,7), tw 1,1,1,1
  - stage1 pairs (0,2)(1,3)(4,6)(5,7), tw 2,2,3,3
  - stage2 pairs (0,1)(2,3)(4,5)(6,7), tw 4,5,6,7
  - stage1 first read at cycle 14; done at cycle 40.
- LOGN=3, mode=1:
  - stage0 pairs (0,1)(2,3)(4,5)(6,7), tw 4,5,6,7
  - stage2 pairs (0,4)..(3,7), tw 1
  - tw_inv=1 and op=01 throughout; done at cycle 40.
- LOGN=3, mode=2:
  - rd_addr1=rd_addr2=0..7 on cycles 1..8, rd_bsel=1.
  - wr_en1 on cycles 10..17 with wr_addr1 0..7; wr_en2 never asserted; done at cycle 18.
- Alignment check:
  - op_vld rises exactly RD_LAT cycles after rd_en.
  - wr_addr1 at cycle t+9 equals rd_addr1 at cycle t, for every issue.
- Protocol check:
  - start while busy: no effect.
  - start with mode=3: stays IDLE, busy=0, no done.
- rst=1 at cycle 20 of an NTT: every output is 0 in cycle 21; no wr_en afterwards; a fresh start at cycle 25 gives done at cycle 65.

Source files
------------

// File: rtl/ntt_seq.sv
// Stage sequencer and address generator for a single-BFU NTT/INTT/pointwise engine.
// Issues operand/twiddle reads one per cycle and replays the read addresses as write addresses after the BFU latency.
module ntt_seq #(
  parameter int unsigned LOGN    = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned BFU_LAT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr1,
  output logic [LOGN-1:0] rd_addr2,
  output logic            rd_bsel,
  output logic [LOGN-1:0] tw_addr,
  output logic            tw_inv,
  output logic [1:0]      op,
  output logic            op_vld,
  output logic            wr_en1,
  output logic            wr_en2,
  output logic [LOGN-1:0] wr_addr1,
  output logic [LOGN-1:0] wr_addr2
);

  localparam int unsigned N   = 1 << LOGN;
  localparam int unsigned AW  = LOGN;
  localparam int unsigned SW  = $clog2(LOGN + 1);
  localparam int unsigned DLY = RD_LAT + BFU_LAT;
  localparam int unsigned DW  = $clog2(DLY + 1);
  // One delay stage lives in the output registers, the rest in the pipe.
  localparam int unsigned WP  = DLY - 1;

  localparam logic [1:0] MODE_NTT  = 2'd0;
  localparam logic [1:0] MODE_INTT = 2'd1;
  localparam logic [1:0] MODE_PW   = 2'd2;
  localparam logic [1:0] MODE_RSV  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic          en;
    logic          pw;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
  } wb_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] op;
  } opp_t;

  state_t        state_q, state_nxt;
  logic [AW-1:0] j_q, j_nxt;
  logic [SW-1:0] stage_q, stage_nxt;
  logic [DW-1:0] dcnt_q, dcnt_nxt;
  logic [1:0]    mode_q, mode_nxt;
  logic [AW-1:0] j_last;
  logic [SW-1:0] last_stage;

  logic [SW-1:0] sh, tsh;
  logic [AW-1:0] len, g, k, a1, a2, tw;
  logic          iss_inv, iss_bsel, issue;
  logic [1:0]    iss_op;
  logic [1:0]    op_iss_q;

  wb_t  wr_pipe_q [WP];
  opp_t op_pipe_q [RD_LAT];

  assign j_last     = (mode_q == MODE_PW) ? AW'(N - 1) : AW'(N / 2 - 1);
  assign last_stage = (mode_q == MODE_PW) ? SW'(0) : SW'(LOGN - 1);

  // Next-state: RUN walks j, DRAIN waits out the read+BFU pipeline before the next stage.
  always_comb begin
    state_nxt = state_q;
    j_nxt     = j_q;
    stage_nxt = stage_q;
    dcnt_nxt  = dcnt_q;
    mode_nxt  = mode_q;
    case (state_q)
      IDLE: begin
        if (start && (mode != MODE_RSV)) begin
          state_nxt = RUN;
          j_nxt     = '0;
          stage_nxt = '0;
          mode_nxt  = mode;
        end
      end
      RUN: begin
        if (j_q == j_last) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end else begin
          j_nxt = j_q + AW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(DLY - 1)) begin
          if (stage_q == last_stage) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            stage_nxt = stage_q + SW'(1);
            j_nxt     = '0;
          end
        end else begin
          dcnt_nxt = dcnt_q + DW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address generation for the op about to issue; NTT and INTT swap the roles of the two shift amounts.
  always_comb begin
    sh       = '0;
    tsh      = '0;
    len      = '0;
    g        = '0;
    k        = '0;
    a1       = '0;
    a2       = '0;
    tw       = '0;
    iss_inv  = 1'b0;
    iss_bsel = 1'b0;
    iss_op   = 2'b00;
    issue    = (state_nxt == RUN);
    case (mode_nxt)
      MODE_NTT: begin
        sh  = SW'(LOGN - 1) - stage_nxt;
        tsh = stage_nxt;
      end
      MODE_INTT: begin
        sh      = stage_nxt;
        tsh     = SW'(LOGN - 1) - stage_nxt;
        iss_inv = 1'b1;
        iss_op  = 2'b01;
      end
      default: begin
        iss_bsel = 1'b1;
        iss_op   = 2'b10;
      end
    endcase
    if (mode_nxt == MODE_PW) begin
      a1 = j_nxt;
      a2 = j_nxt;
    end else begin
      len = AW'(1) << sh;
      g   = j_nxt >> sh;
      k   = j_nxt & (len - AW'(1));
      a1  = (g << (sh + SW'(1))) | k;
      a2  = a1 + len;
      tw  = (AW'(1) << tsh) + g;
    end
  end

  // State, counters and issue-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      j_q      <= '0;
      stage_q  <= '0;
      dcnt_q   <= '0;
      mode_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      rd_bsel  <= 1'b0;
      tw_addr  <= '0;
      tw_inv   <= 1'b0;
      op_iss_q <= 2'b00;
    end else begin
      state_q  <= state_nxt;
      j_q      <= j_nxt;
      stage_q  <= stage_nxt;
      dcnt_q   <= dcnt_nxt;
      mode_q   <= mode_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      rd_en    <= issue;
      rd_addr1 <= issue ? a1 : '0;
      rd_addr2 <= issue ? a2 : '0;
      rd_bsel  <= issue & iss_bsel;
      tw_addr  <= issue ? tw : '0;
      tw_inv   <= issue & iss_inv;
      op_iss_q <= issue ? iss_op : 2'b00;
    end
  end

  // Op code follows the RAM read data by RD_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) op_pipe_q[i] <= '0;
    end else begin
      op_pipe_q[0] <= '{vld: rd_en, op: op_iss_q};
      for (int i = 1; i < int'(RD_LAT); i++) op_pipe_q[i] <= op_pipe_q[i-1];
    end
  end

  assign op_vld = op_pipe_q[RD_LAT-1].vld;
  assign op     = op_pipe_q[RD_LAT-1].op;

  // Write-back delay line; the pointwise tag suppresses the second write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WP); i++) wr_pipe_q[i] <= '0;
      wr_en1   <= 1'b0;
      wr_en2   <= 1'b0;
      wr_addr1 <= '0;
      wr_addr2 <= '0;
    end else begin
      wr_pipe_q[0] <= '{en: rd_en, pw: rd_bsel, a1: rd_addr1, a2: rd_addr2};
      for (int i = 1; i < int'(WP); i++) wr_pipe_q[i] <= wr_pipe_q[i-1];
      wr_en1   <= wr_pipe_q[WP-1].en;
      wr_en2   <= wr_pipe_q[WP-1].en & ~wr_pipe_q[WP-1].pw;
      wr_addr1 <= wr_pipe_q[WP-1].a1;
      wr_addr2 <= wr_pipe_q[WP-1].a2;
    end
  end

endmodule

// File: tb/tb_ntt_seq.sv
// Scoreboard bench for ntt_seq at LOGN=3: expected reads, op slots, writes and done
// are queued with their cycle numbers when a start is driven, and matched as outputs appear.
module tb_ntt_seq;

  localparam int LOGN    = 3;
  localparam int RD_LAT  = 1;
  localparam int BFU_LAT = 8;
  localparam int N       = 1 << LOGN;
  localparam int D       = RD_LAT + BFU_LAT;

  logic            clk;
  logic            rst;
  logic            start;
  logic [1:0]      mode;
  logic            busy, done, rd_en, rd_bsel, tw_inv, op_vld, wr_en1, wr_en2;
  logic [LOGN-1:0] rd_addr1, rd_addr2, tw_addr, wr_addr1, wr_addr2;
  logic [1:0]      op;

  typedef struct {
    int cyc; int a1; int a2; int tw; int inv; int op; int bsel;
  } iss_t;
  typedef struct { int cyc; int op; } opx_t;
  typedef struct { int cyc; int a1; int a2; int en2; } wbx_t;

  iss_t iss_q[$];
  opx_t op_q[$];
  wbx_t wr_q[$];
  int   done_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  ntt_seq #(.LOGN(LOGN), .RD_LAT(RD_LAT), .BFU_LAT(BFU_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_bsel(rd_bsel),
    .tw_addr(tw_addr), .tw_inv(tw_inv), .op(op), .op_vld(op_vld),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected schedule built directly from the transform definitions.
  task automatic push_run(input int m, input int t0);
    int stages, mm, c, len, g, k, a1, a2, tw;
    iss_t e;
    opx_t o;
    wbx_t w;
    stages = (m == 2) ? 1 : LOGN;
    mm     = (m == 2) ? N : N / 2;
    for (int s = 0; s < stages; s++) begin
      for (int j = 0; j < mm; j++) begin
        c = t0 + 1 + s * (mm + D) + j;
        if (m == 0) begin
          len = N >> (s + 1);
          g   = j >> (LOGN - 1 - s);
          k   = j & (len - 1);
          a1  = 2 * g * len + k;
          a2  = a1 + len;
          tw  = (1 << s) + g;
        end else if (m == 1) begin
          len = 1 << s;
          g   = j >> s;
          k   = j & (len - 1);
          a1  = 2 * g * len + k;
          a2  = a1 + len;
          tw  = (N >> (s + 1)) + g;
        end else begin
          a1 = j;
          a2 = j;
          tw = 0;
        end
        e = '{c, a1, a2, tw, (m == 1) ? 1 : 0, m, (m == 2) ? 1 : 0};
        iss_q.push_back(e);
        o = '{c + RD_LAT, m};
        op_q.push_back(o);
        w = '{c + D, a1, a2, (m == 2) ? 0 : 1};
        wr_q.push_back(w);
      end
    end
    done_q.push_back(t0 + 1 + stages * (mm + D));
  endtask

  // Caller is at a negedge; start is sampled on the following posedge (cycle t0).
  task automatic do_start(input int m, input bit expect_run, output int t0);
    start = 1'b1;
    mode  = 2'(m);
    t0    = cyc;
    if (expect_run) push_run(m, t0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int i;
    i = 0;
    while ((iss_q.size() + op_q.size() + wr_q.size() + done_q.size()) != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if ((iss_q.size() + op_q.size() + wr_q.size() + done_q.size()) != 0)
      check("timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  iss_t me;
  opx_t mo;
  wbx_t mw;
  int   md;

  // Output monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (rd_en) begin
      if (iss_q.size() == 0) check("rd_unexp", 1, 0);
      else begin
        me = iss_q.pop_front();
        check("rd_cyc", cyc, me.cyc);
        check("rd_addr1", int'(rd_addr1), me.a1);
        check("rd_addr2", int'(rd_addr2), me.a2);
        check("tw_addr", int'(tw_addr), me.tw);
        check("tw_inv", int'(tw_inv), me.inv);
        check("rd_bsel", int'(rd_bsel), me.bsel);
      end
    end
    if (op_vld) begin
      if (op_q.size() == 0) check("op_unexp", 1, 0);
      else begin
        mo = op_q.pop_front();
        check("op_cyc", cyc, mo.cyc);
        check("op", int'(op), mo.op);
      end
    end else if (op != 2'b00) begin
      check("op_idle", int'(op), 0);
    end
    if (wr_en1) begin
      if (wr_q.size() == 0) check("wr_unexp", 1, 0);
      else begin
        mw = wr_q.pop_front();
        check("wr_cyc", cyc, mw.cyc);
        check("wr_addr1", int'(wr_addr1), mw.a1);
        check("wr_addr2", int'(wr_addr2), mw.a2);
        check("wr_en2", int'(wr_en2), mw.en2);
      end
    end else if (wr_en2) begin
      check("wr_en2_alone", 1, 0);
    end
    if (done) begin
      if (done_q.size() == 0) check("done_unexp", 1, 0);
      else begin
        md = done_q.pop_front();
        check("done_cyc", cyc, md);
        check("busy_at_done", int'(busy), 1);
      end
    end
  end

  int t0, tr;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({busy, done, rd_en, rd_addr1, rd_addr2, rd_bsel, tw_addr, tw_inv,
                             op, op_vld, wr_en1, wr_en2, wr_addr1, wr_addr2}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Forward, inverse and pointwise transforms.
    for (int m = 0; m < 3; m++) begin
      do_start(m, 1'b1, t0);
      wait_empty(200);
    end

    // start during an operation is ignored.
    do_start(0, 1'b1, t0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    mode  = 2'd2;
    @(negedge clk);
    start = 1'b0;
    wait_empty(200);

    // Reserved mode never leaves IDLE.
    do_start(3, 1'b0, t0);
    for (int i = 0; i < 6; i++) begin
      check("rsv_busy", int'(busy), 0);
      @(negedge clk);
    end

    // Reset in the middle of an NTT, then a fresh start.
    do_start(0, 1'b1, tr);
    while (cyc < tr + 20) @(negedge clk);
    rst = 1'b1;
    iss_q.delete();
    op_q.delete();
    wr_q.delete();
    done_q.delete();
    @(negedge clk);
    check("rst_mid_outs", 32'({busy, done, rd_en, rd_addr1, rd_addr2, rd_bsel, tw_addr, tw_inv,
                               op, op_vld, wr_en1, wr_en2, wr_addr1, wr_addr2}), 0);
    rst = 1'b0;
    while (cyc < tr + 25) @(negedge clk);
    do_start(0, 1'b1, t0);
    check("restart_cyc", t0 - tr, 25);
    wait_empty(200);

    check("iss_left", iss_q.size(), 0);
    check("op_left", op_q.size(), 0);
    check("wr_left", wr_q.size(), 0);
    check("done_left", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
